// File: rtl/tmr_scrub_reg.sv
// Triple-redundant register with bitwise 2-of-3 vote, periodic scrubbing,
// a saturating corrected-upset counter and a test-only fault-injection port.
module tmr_scrub_reg #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int unsigned      SCRUB_PERIOD = 16,
    parameter int unsigned      CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             mismatch,
    output logic             scrub_tick,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    input  logic             clr_err
);

    localparam int unsigned      TW       = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0]    TMR_LAST = TW'(SCRUB_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] c_q [3];
    logic [WIDTH-1:0] c_d [3];
    logic [TW-1:0]    timer_q, timer_d;
    logic             mismatch_q, mismatch_d;
    logic             scrub_tick_q, scrub_tick_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    logic [WIDTH-1:0] maj;
    logic             disagree;
    logic             scrub_evt;
    logic             corrected;

    always_comb begin
        maj       = (c_q[0] & c_q[1]) | (c_q[1] & c_q[2]) | (c_q[0] & c_q[2]);
        disagree  = |((c_q[0] ^ c_q[1]) | (c_q[1] ^ c_q[2]));
        scrub_evt = (timer_q == TMR_LAST);
        corrected = scrub_evt && !load && disagree;
    end

    // Injection is XORed after the scrub write so a fault planted on a
    // scrub edge survives until the following scrub.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            c_d[i] = c_q[i];
            if (load) begin
                c_d[i] = d;
            end else begin
                if (scrub_evt) c_d[i] = maj;
                if (inj_en && (inj_sel == 2'(i))) c_d[i] = c_d[i] ^ inj_mask;
            end
        end
    end

    always_comb begin
        timer_d      = scrub_evt ? '0 : timer_q + TW'(1);
        mismatch_d   = disagree;
        scrub_tick_d = scrub_evt;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (corrected) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) c_q[i] <= RESET_VAL;
            timer_q      <= '0;
            mismatch_q   <= 1'b0;
            scrub_tick_q <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) c_q[i] <= c_d[i];
            timer_q      <= timer_d;
            mismatch_q   <= mismatch_d;
            scrub_tick_q <= scrub_tick_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        q          = maj;
        mismatch   = mismatch_q;
        scrub_tick = scrub_tick_q;
        err_cnt    = err_cnt_q;
        err_sticky = err_sticky_q;
    end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Directed, table-driven bench for tmr_scrub_reg (8-bit, reset 8'hA5,
// scrub every 4 cycles, 2-bit counter); scrubs land on edges 4, 8, 12, ...
module tb_tmr_scrub_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] d;
    logic [7:0] q;
    logic       inj_en;
    logic [1:0] inj_sel;
    logic [7:0] inj_mask;
    logic       mismatch;
    logic       scrub_tick;
    logic [1:0] err_cnt;
    logic       err_sticky;
    logic       clr_err;

    int tests  = 0;
    int failed = 0;

    tmr_scrub_reg #(
        .WIDTH       (8),
        .RESET_VAL   (8'hA5),
        .SCRUB_PERIOD(4),
        .CNT_W       (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .d         (d),
        .q         (q),
        .inj_en    (inj_en),
        .inj_sel   (inj_sel),
        .inj_mask  (inj_mask),
        .mismatch  (mismatch),
        .scrub_tick(scrub_tick),
        .err_cnt   (err_cnt),
        .err_sticky(err_sticky),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [7:0] d;
        logic       inj_en;
        logic [1:0] sel;
        logic [7:0] mask;
        logic       clr;
        logic [7:0] q;
        logic       mm;
        logic       tick;
        logic [1:0] cnt;
        logic       st;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [7:0] dv, input logic ie, input logic [1:0] sel,
                       input logic [7:0] m, input logic clr, input logic [7:0] eq, input logic emm,
                       input logic etk, input logic [1:0] ecnt, input logic est);
        vec_t v;
        v.load = ld; v.d = dv; v.inj_en = ie; v.sel = sel; v.mask = m; v.clr = clr;
        v.q = eq; v.mm = emm; v.tick = etk; v.cnt = ecnt; v.st = est;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        load = 1'b0; d = '0; inj_en = 1'b0; inj_sel = '0; inj_mask = '0; clr_err = 1'b0;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [7:0] eq, input logic emm,
                             input logic etk, input logic [1:0] ecnt, input logic est);
        chk({tag, "_q"}, idx, 32'(q), 32'(eq));
        chk({tag, "_mismatch"}, idx, 32'(mismatch), 32'(emm));
        chk({tag, "_tick"}, idx, 32'(scrub_tick), 32'(etk));
        chk({tag, "_cnt"}, idx, 32'(err_cnt), 32'(ecnt));
        chk({tag, "_sticky"}, idx, 32'(err_sticky), 32'(est));
    endtask

    initial begin
        // Edge-by-edge vectors; expected values are after that edge.
        //   ld  d      ie sel mask  clr | q      mm tk cnt st
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0); // E1
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0); // E2
        add(1, 8'h3C, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 0); // E3 load
        add(0, 8'h00, 1, 1, 8'h01, 0, 8'h3C, 0, 1, 0, 0); // E4 scrub + inject c1
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0); // E5
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0); // E6
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0); // E7
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 1, 1, 1, 1); // E8 corrected
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 1, 1); // E9
        add(0, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 0, 0); // E10 clr
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 0); // E11
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 1, 0, 0); // E12 clean scrub
        add(0, 8'h00, 1, 0, 8'h80, 0, 8'h3C, 0, 0, 0, 0); // E13 c0 bit7
        add(0, 8'h00, 1, 1, 8'h80, 0, 8'hBC, 1, 0, 0, 0); // E14 c1 bit7 -> double upset
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0); // E15
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 1, 1); // E16 scrub propagates BC
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 1, 1); // E17
        add(0, 8'h00, 1, 2, 8'hFF, 0, 8'hBC, 0, 0, 1, 1); // E18 corrupt c2
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'hBC, 1, 0, 1, 1); // E19
        add(1, 8'h5A, 1, 0, 8'h01, 0, 8'h5A, 1, 1, 1, 1); // E20 load on scrub edge
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 1, 1); // E21
        add(0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 0, 0, 0, 0); // E22 clr
        add(0, 8'h00, 1, 0, 8'h01, 0, 8'h5A, 0, 0, 0, 0); // E23
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 1, 1); // E24 cnt 1
        add(0, 8'h00, 1, 1, 8'h01, 0, 8'h5A, 0, 0, 1, 1); // E25
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 1, 1); // E26
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 1, 1); // E27
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 2, 1); // E28 cnt 2
        add(0, 8'h00, 1, 2, 8'h01, 0, 8'h5A, 0, 0, 2, 1); // E29
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 2, 1); // E30
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 2, 1); // E31
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 3, 1); // E32 cnt 3
        add(0, 8'h00, 1, 0, 8'h01, 0, 8'h5A, 0, 0, 3, 1); // E33
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E34
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E35
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 3, 1); // E36 saturated
        add(0, 8'h00, 1, 1, 8'h02, 0, 8'h5A, 0, 0, 3, 1); // E37
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E38
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E39
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 3, 1); // E40 saturated
        add(0, 8'h00, 1, 2, 8'h80, 0, 8'h5A, 0, 0, 3, 1); // E41
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E42
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 3, 1); // E43
        add(0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 1, 1, 0, 0); // E44 clr beats increment
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 0, 0); // E45
        add(0, 8'h00, 1, 3, 8'hFF, 0, 8'h5A, 0, 0, 0, 0); // E46 sel 3 no effect
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 0, 0); // E47
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 1, 0, 0); // E48 clean scrub
        add(0, 8'h00, 1, 1, 8'h00, 0, 8'h5A, 0, 0, 0, 0); // E49 zero mask
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 0, 0); // E50
        add(0, 8'h00, 1, 0, 8'hF0, 0, 8'h5A, 0, 0, 0, 0); // E51
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 1, 1); // E52
        add(0, 8'h00, 1, 2, 8'h0F, 0, 8'h5A, 0, 0, 1, 1); // E53
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 1, 1); // E54

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 8'hA5, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            load = vq[i].load; d = vq[i].d; inj_en = vq[i].inj_en;
            inj_sel = vq[i].sel; inj_mask = vq[i].mask; clr_err = vq[i].clr;
            @(posedge clk);
            #1;
            check_all("vec", i + 1, vq[i].q, vq[i].mm, vq[i].tick, vq[i].cnt, vq[i].st);
        end

        // Asynchronous reset mid-period with copies disagreeing.
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 8'hA5, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            check_all("post_rst", j, 8'hA5, 0, (j == 4), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tmr_scrub_reg.md
Name: tmr_scrub_reg

Overview:
- Parametrised radiation-hardened register for the PVT monitor datapath.
- Holds three redundant WIDTH-bit copies and drives a bitwise 2-of-3 majority output.
- Periodically rewrites all copies from the voted value (scrubbing) and counts corrected upsets.
- A test-only fault-injection port lets benches and silicon self-test corrupt single copies.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- RESET_VAL, 0, value loaded into all three copies on reset (WIDTH bits)
- SCRUB_PERIOD, 16, cycles between scrub events (>=1; 1 = scrub every cycle)
- CNT_W, 8, width of saturating corrected-upset counter (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  write d into all three copies at this edge
- d  input  WIDTH  load data
- q  output  WIDTH  bitwise majority of the three copies (combinational from copy registers)
- inj_en  input  1  fault-injection strobe
- inj_sel  input  2  target copy 0..2; value 3 = no effect
- inj_mask  input  WIDTH  XOR mask applied to target copy
- mismatch  output  1  registered: copies disagreed in any bit during the previous cycle
- scrub_tick  output  1  one-cycle pulse, high in the cycle after a scrub write
- err_cnt  output  CNT_W  corrected-upset counter, saturating
- err_sticky  output  1  set on any corrected upset, held until clr_err
- clr_err  input  1  synchronous clear of err_cnt and err_sticky

Behaviour:
- Reset (async, rst_n=0): copies c0/c1/c2 = RESET_VAL; q = RESET_VAL; scrub timer = 0; mismatch = 0; scrub_tick = 0; err_cnt = 0; err_sticky = 0. Reset mid-scrub or mid-injection discards everything.
- Majority: q[i] = (c0&c1)|(c1&c2)|(c0&c2) per bit. No extra latency: a load at edge N is visible on q after edge N.
- Disagree (internal, combinational): OR over bits of (c0^c1)|(c1^c2). mismatch <= disagree each cycle.
- Scrub timer: free-running, 0..SCRUB_PERIOD-1, wraps to 0. Counts regardless of load or injection. A scrub event occurs at the edge where the timer == SCRUB_PERIOD-1.
- Next-state priority per copy:
  1. load=1: all copies <= d. Scrub and injection are ignored that edge. The timer still advances. No error count.
  2. Otherwise, on a scrub event: all copies <= majority.
  3. Otherwise: hold.
  4. Injection: if load=0, inj_en=1 and inj_sel<3, copy[inj_sel] next value ^= inj_mask. Applied on top of a scrub write, so an error injected at a scrub edge survives until the next scrub.
- scrub_tick <= 1 at every scrub event edge, including when load overrides the write.
- Corrected upset: a scrub event with load=0 and disagree=1.
  - err_cnt increments by 1 per event and saturates at 2^CNT_W-1 (no wrap).
  - err_sticky <= 1.
- clr_err=1: err_cnt <= 0 and err_sticky <= 0. Clear wins over a same-cycle increment.
- Double upset in the same bit of two copies is not detectable as wrong. q follows the corrupted majority and scrub propagates it. This is documented behaviour, not a bug.
- Inject mask 0 is a no-op and causes no mismatch.

Test Plan:
- Reset with RESET_VAL=8'hA5, then release -> q=8'hA5, err_cnt=0, mismatch=0, scrub_tick=0 until first timer wrap.
- load d=8'h3C; one cycle later inject inj_sel=1, inj_mask=8'h01 -> q stays 8'h3C; mismatch=1 next cycle; at next scrub c1 is restored; err_cnt=1, err_sticky=1, scrub_tick pulses; mismatch returns to 0 one cycle after scrub.
- SCRUB_PERIOD=4: inject mask 8'h80 into copy 0 and copy 1 in consecutive cycles between scrubs -> q bit7 flips (8'h3C -> 8'hBC); scrub propagates 8'hBC; err_cnt increments once.
- load=1 coincident with a scrub edge while copy 2 is corrupted -> all copies = d, err_cnt unchanged, scrub_tick=1.
- CNT_W=2: force 5 corrected scrubs -> err_cnt sequence 1,2,3,3,3; then clr_err=1 in the same cycle as a 6th corrected scrub -> err_cnt=0, err_sticky=0.
- inj_sel=3 with inj_mask=8'hFF, and deassert rst_n mid-period after an injection -> no effect in the first case; in the second, all outputs return to reset values immediately (asynchronously).
